// File: rtl/blast_pkg.sv
// Shared lane codes and sequencer state encoding for the Blast hit judge and score calculator.
package blast_pkg;

  localparam logic [1:0] CODE_MISS = 2'd0;
  localparam logic [1:0] CODE_HIT  = 2'd1;
  localparam logic [1:0] CODE_NONE = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_WINDOW,
    ST_REPORT,
    ST_DONE
  } state_t;

  function automatic logic [1:0] lane_code(input logic tgt, input logic hit);
    return !tgt ? CODE_NONE : (hit ? CODE_HIT : CODE_MISS);
  endfunction

endpackage

// File: rtl/blast_hit_judge_if.sv
// Judge interface between the hit judge (master) and the score calculator (slave).
interface blast_hit_judge_if;
  logic [1:0] b1;
  logic [1:0] b2;
  logic       startCalc;
  logic       stop;

  modport master (output b1, b2, startCalc, stop);
  modport slave  (input  b1, b2, startCalc, stop);
endinterface

// File: rtl/blast_btn_sync.sv
// Button conditioner: 2-FF synchroniser, optional debounce (BLAST_DEBOUNCE_EN), rising-edge pulse.
module blast_btn_sync #(
  parameter int unsigned DEB_CYC = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  if (DEB_CYC < 1) begin : g_bad_cfg
    $error("blast_btn_sync: DEB_CYC must be >= 1");
  end

  logic s1, s2, lvl, lvl_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      lvl_q <= 1'b0;
    end else begin
      s1    <= btn;
      s2    <= s1;
      lvl_q <= lvl;
    end
  end

`ifdef BLAST_DEBOUNCE_EN
  localparam int unsigned DW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  logic [DW-1:0] cnt;

  // lvl only follows s2 once DEB_CYC consecutive samples disagree with it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lvl <= 1'b0;
      cnt <= '0;
    end else if (s2 == lvl) begin
      cnt <= '0;
    end else if (cnt == DW'(DEB_CYC - 1)) begin
      lvl <= s2;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  assign lvl = s2;
`endif

  assign press = lvl & ~lvl_q;

endmodule

// File: rtl/blast_hit_judge.sv
// Blast round sequencer and hit judge; optional button debounce via BLAST_DEBOUNCE_EN.
module blast_hit_judge
  import blast_pkg::*;
#(
  parameter int unsigned WIN_CYC = 50_000_000,
  parameter int unsigned ROUNDS  = 20,
  parameter int unsigned DEB_CYC = 500_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               game_start,
  input  logic               game_over,
  input  logic               spawn,
  input  logic               tgt1,
  input  logic               tgt2,
  input  logic               btn1,
  input  logic               btn2,
  blast_hit_judge_if.master  jdg,
  output logic [4:0]         round_cnt,
  output logic               busy
);

  localparam int unsigned CW = (WIN_CYC > 1) ? $clog2(WIN_CYC) : 1;

  state_t          state;
  logic [CW-1:0]   win_cnt;
  logic            tgt1_q, tgt2_q, hit1, hit2;
  logic            press1, press2;
  logic            hit1_n, hit2_n;

  blast_btn_sync #(.DEB_CYC(DEB_CYC)) u_sync1 (.clk(clk), .rst(rst), .btn(btn1), .press(press1));
  blast_btn_sync #(.DEB_CYC(DEB_CYC)) u_sync2 (.clk(clk), .rst(rst), .btn(btn2), .press(press2));

  // include the current cycle's press so the last window cycle still counts
  assign hit1_n = hit1 | (press1 & tgt1_q);
  assign hit2_n = hit2 | (press2 & tgt2_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_IDLE;
      win_cnt       <= '0;
      tgt1_q        <= 1'b0;
      tgt2_q        <= 1'b0;
      hit1          <= 1'b0;
      hit2          <= 1'b0;
      jdg.b1        <= CODE_NONE;
      jdg.b2        <= CODE_NONE;
      jdg.startCalc <= 1'b0;
      jdg.stop      <= 1'b0;
      round_cnt     <= '0;
      busy          <= 1'b0;
    end else begin
      jdg.startCalc <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (game_start) begin
            state     <= ST_WAIT;
            round_cnt <= '0;
            busy      <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (game_over) begin
            state    <= ST_DONE;
            jdg.stop <= 1'b1;
            busy     <= 1'b0;
          end else if (spawn) begin
            state   <= ST_WINDOW;
            tgt1_q  <= tgt1;
            tgt2_q  <= tgt2;
            hit1    <= 1'b0;
            hit2    <= 1'b0;
            win_cnt <= CW'(WIN_CYC - 1);
          end
        end
        ST_WINDOW: begin
          if (game_over) begin
            state    <= ST_DONE;
            jdg.stop <= 1'b1;
            busy     <= 1'b0;
          end else begin
            hit1 <= hit1_n;
            hit2 <= hit2_n;
            if (win_cnt == '0) begin
              state         <= ST_REPORT;
              jdg.startCalc <= 1'b1;
              jdg.b1        <= lane_code(tgt1_q, hit1_n);
              jdg.b2        <= lane_code(tgt2_q, hit2_n);
            end else begin
              win_cnt <= win_cnt - 1'b1;
            end
          end
        end
        ST_REPORT: begin
          round_cnt <= round_cnt + 1'b1;
          if (game_over || (round_cnt == 5'(ROUNDS - 1))) begin
            state    <= ST_DONE;
            jdg.stop <= 1'b1;
            busy     <= 1'b0;
          end else begin
            state <= ST_WAIT;
          end
        end
        ST_DONE: begin
          if (!game_over && game_start) begin
            state     <= ST_WAIT;
            round_cnt <= '0;
            jdg.stop  <= 1'b0;
            busy      <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
